// File: rtl/pattern_chk_pkg.sv
// Shared types and default parameters for the counter-pattern receive checker.
package pattern_chk_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   localparam int DEF_WIDTH         = 8;
   localparam int DEF_LOCK_COUNT    = 4;
   localparam int DEF_LOSS_THRESH   = 4;
   localparam int DEF_ERR_CNT_WIDTH = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/counter_pattern_checker.sv
// Locks onto a looped-back incrementing counter stream and flags every sample
// that breaks the +1 rule once locked.
module counter_pattern_checker
   import pattern_chk_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
   parameter int LOSS_THRESH   = DEF_LOSS_THRESH,
   parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     clear,
   output logic                     locked,
   output logic                     err_pulse,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic [1:0]               state
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int LOSS_W = $clog2(LOSS_THRESH + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   prev_q, prev_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [LOSS_W-1:0]  loss_q, loss_d;
   logic               locked_q, locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic [WIDTH-1:0]   expected;
   logic               mism;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SEARCH;
         prev_q      <= '0;
         run_q       <= '0;
         loss_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         run_q       <= run_d;
         loss_q      <= loss_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign expected = prev_q + WIDTH'(1);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      run_d   = run_q;
      loss_d  = loss_q;
      mism    = 1'b0;
      case (state_q)
         SEARCH: begin
            if (en) begin
               prev_d  = din;
               run_d   = '0;
               state_d = LOCKING;
            end
         end
         LOCKING: begin
            if (en) begin
               prev_d = din;
               if (din == expected) begin
                  run_d = run_q + RUN_W'(1);
                  if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
                     state_d = LOCKED;
                  end
               end else begin
                  run_d = '0;
               end
            end
         end
         LOCKED: begin
            // Reference free-runs so one corrupted sample costs exactly one error.
            if (en) begin
               prev_d = expected;
               if (din == expected) begin
                  loss_d = '0;
               end else begin
                  mism = 1'b1;
                  if (loss_q == LOSS_W'(LOSS_THRESH - 1)) begin
                     state_d = SEARCH;
                     run_d   = '0;
                     loss_d  = '0;
                  end else begin
                     loss_d = loss_q + LOSS_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = SEARCH;
            run_d   = '0;
            loss_d  = '0;
         end
      endcase
   end

   always_comb begin
      locked_d    = (state_d == LOCKED);
      err_pulse_d = mism;
   end

   sat_counter #(
      .W (ERR_CNT_WIDTH)
   ) u_err_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (mism),
      .clr_i   (clear),
      .count_o (err_count)
   );

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign state     = state_q;

endmodule

// File: tb/tb_counter_pattern_checker.sv
// Scoreboard bench: two checker instances (default and narrow-counter/high-threshold)
// share one stimulus stream; a behavioural model queues expected outputs per sample.
module tb_counter_pattern_checker;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] din;
   logic       clear;

   logic        locked_a, err_pulse_a;
   logic [15:0] err_count_a;
   logic [1:0]  state_a;
   logic        locked_b, err_pulse_b;
   logic [3:0]  err_count_b;
   logic [1:0]  state_b;

   counter_pattern_checker u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .din       (din),
      .clear     (clear),
      .locked    (locked_a),
      .err_pulse (err_pulse_a),
      .err_count (err_count_a),
      .state     (state_a)
   );

   counter_pattern_checker #(
      .WIDTH         (8),
      .LOCK_COUNT    (4),
      .LOSS_THRESH   (32),
      .ERR_CNT_WIDTH (4)
   ) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .din       (din),
      .clear     (clear),
      .locked    (locked_b),
      .err_pulse (err_pulse_b),
      .err_count (err_count_b),
      .state     (state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int lk;
      int pl;
      int cnt;
      int st;
   } exp_t;

   exp_t       sb_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   int         m_st[2];
   logic [7:0] m_prev[2];
   int         m_run[2];
   int         m_loss[2];
   int         m_cnt[2];
   int         m_pulse[2];
   int         thresh[2] = '{4, 32};
   int         cmax[2]   = '{65535, 15};

   task automatic check_val(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_prev[k] = 8'h00; m_run[k] = 0;
         m_loss[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input logic e, input logic [7:0] d, input logic c);
      logic [7:0] nx;
      logic       mis;
      nx = m_prev[k] + 8'd1;
      mis = 1'b0;
      m_pulse[k] = 0;
      if (e) begin
         if (m_st[k] == 0) begin
            m_prev[k] = d; m_run[k] = 0; m_st[k] = 1;
         end else if (m_st[k] == 1) begin
            if (d == nx) begin
               m_run[k]++;
               if (m_run[k] == 4) m_st[k] = 2;
            end else begin
               m_run[k] = 0;
            end
            m_prev[k] = d;
         end else begin
            m_prev[k] = nx;
            if (d == nx) begin
               m_loss[k] = 0;
            end else begin
               mis = 1'b1;
               m_pulse[k] = 1;
               m_loss[k]++;
               if (m_loss[k] == thresh[k]) begin
                  m_st[k] = 0; m_run[k] = 0; m_loss[k] = 0;
               end
            end
         end
      end
      if (c) m_cnt[k] = 0;
      else if (mis && m_cnt[k] < cmax[k]) m_cnt[k]++;
   endtask

   task automatic compare_all();
      exp_t ea, eb;
      ea = sb_q.pop_front();
      eb = sb_q.pop_front();
      check_val("a.locked", int'(locked_a), ea.lk);
      check_val("a.err_pulse", int'(err_pulse_a), ea.pl);
      check_val("a.err_count", int'(err_count_a), ea.cnt);
      check_val("a.state", int'(state_a), ea.st);
      check_val("b.locked", int'(locked_b), eb.lk);
      check_val("b.err_pulse", int'(err_pulse_b), eb.pl);
      check_val("b.err_count", int'(err_count_b), eb.cnt);
      check_val("b.state", int'(state_b), eb.st);
   endtask

   task automatic push_expected();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         e.lk = (m_st[k] == 2) ? 1 : 0;
         e.pl = m_pulse[k];
         e.cnt = m_cnt[k];
         e.st = m_st[k];
         sb_q.push_back(e);
      end
   endtask

   task automatic step(input logic e, input logic [7:0] d, input logic c);
      @(negedge clk);
      en = e; din = d; clear = c;
      for (int k = 0; k < 2; k++) model_step(k, e, d, c);
      push_expected();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // Asserted between edges; outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      push_expected();
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      en = 1'b0; clear = 1'b0;
   endtask

   task automatic lock_at(input logic [7:0] last);
      for (int i = 4; i >= 0; i--) step(1'b1, last - 8'(i), 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] v;
      rst = 1'b1; en = 1'b0; din = 8'h00; clear = 1'b0;
      model_reset();
      #12;
      check_val("rst.locked", int'(locked_a), 0);
      check_val("rst.count", int'(err_count_a), 0);
      check_val("rst.state", int'(state_a), 0);
      @(negedge clk);
      rst = 1'b0;

      // Lock
      lock_at(8'h14);
      check_val("lock.locked", int'(locked_a), 1);
      check_val("lock.state", int'(state_a), 2);

      // Wrap
      do_reset();
      lock_at(8'hFC);
      for (int i = 1; i <= 5; i++) step(1'b1, 8'hFC + 8'(i), 1'b0);
      check_val("wrap.locked", int'(locked_a), 1);
      check_val("wrap.count", int'(err_count_a), 0);

      // Glitch
      do_reset();
      lock_at(8'h2F);
      step(1'b1, 8'h30, 1'b0);
      step(1'b1, 8'h31, 1'b0);
      step(1'b1, 8'h99, 1'b0);
      check_val("glitch.pulse", int'(err_pulse_a), 1);
      step(1'b1, 8'h33, 1'b0);
      check_val("glitch.count", int'(err_count_a), 1);
      check_val("glitch.locked", int'(locked_a), 1);

      // Slip and relock
      do_reset();
      lock_at(8'h40);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
      check_val("slip.count", int'(err_count_a), 4);
      check_val("slip.locked", int'(locked_a), 0);
      check_val("slip.state", int'(state_a), 0);
      for (int i = 4; i <= 8; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
      check_val("relock.locked", int'(locked_a), 1);
      check_val("relock.count", int'(err_count_a), 4);

      // Enable gaps
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h89, 1'b0);
      step(1'b1, 8'h8A, 1'b0);
      check_val("gap.locked", int'(locked_a), 1);
      check_val("gap.count", int'(err_count_a), 4);

      // Saturation
      do_reset();
      lock_at(8'h50);
      v = 8'h51;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, v ^ 8'hA5, 1'b0);
         step(1'b1, v + 8'd1, 1'b0);
         v = v + 8'd2;
      end
      check_val("sat.count_b", int'(err_count_b), 15);
      check_val("sat.count_a", int'(err_count_a), 20);
      check_val("sat.locked_b", int'(locked_b), 1);

      // Clear with mismatch, then clear while disabled
      step(1'b1, v ^ 8'h3C, 1'b1);
      check_val("clr.count", int'(err_count_b), 0);
      check_val("clr.pulse", int'(err_pulse_b), 1);
      v = v + 8'd1;
      step(1'b1, v, 1'b0);
      step(1'b1, v ^ 8'h0F, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check_val("clr_dis.count", int'(err_count_a), 0);
      step(1'b1, v + 8'd2, 1'b0);
      step(1'b1, v ^ 8'hF0, 1'b0);
      check_val("pre_rst.locked", int'(locked_a), 1);

      // Async reset mid-LOCKED
      do_reset();
      check_val("arst.locked", int'(locked_a), 0);
      check_val("arst.count", int'(err_count_a), 0);
      lock_at(8'h07);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/counter_pattern_checker.md
Name: counter_pattern_checker

Overview:
- Receive-side checker for the free-running incrementing counter pattern that the factory-test design drives on its bidirectional pins.
- Samples the looped-back bus and locks onto the count sequence. Once locked, it flags and counts every sample that breaks the increment-by-one rule.
- Sits between the pad inputs and the status and debug outputs, as the other end of the factory-test counter stream.

Parameters:
- WIDTH, 8, sampled bus width; the counter wraps modulo 2^WIDTH.
- LOCK_COUNT, 4, consecutive correct increments required to declare lock.
- LOSS_THRESH, 4, consecutive mismatches while locked that drop lock.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; when low, no state, counter or output changes.
- din  input  WIDTH  sampled counter bus.
- clear  input  1  synchronous clear of err_count only.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatching sample while LOCKED.
- err_count  output  ERR_CNT_WIDTH  saturating count of mismatches while LOCKED.
- state  output  2  current FSM state, for debug.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - state=SEARCH, locked=0, err_pulse=0, err_count=0.
  - Internal prev=0, run=0, loss_run=0.
- All outputs are registered. The effect of the sample taken at edge N is visible right after edge N.
- expected = prev + 1, truncated to WIDTH. The wrap from all-ones to 0 is a match.
- Every register holds when en=0. err_pulse is 0 on any cycle without an enabled mismatch.
- SEARCH (state=0): first enabled sample: prev<=din, run<=0, go to LOCKING.
- LOCKING (state=1):
  - On match: prev<=din, run<=run+1. When run+1==LOCK_COUNT, go to LOCKED and set locked=1 on that edge. Lock is therefore asserted at the (LOCK_COUNT+1)th enabled sample of a clean sequence.
  - On mismatch: prev<=din, run<=0, stay in LOCKING. No err_pulse is raised.
- LOCKED (state=2):
  - The reference free-runs: prev<=expected regardless of din, so an isolated corrupted sample costs exactly one error.
  - On match: loss_run<=0.
  - On mismatch: err_pulse<=1, err_count increments (saturating at all-ones), loss_run<=loss_run+1.
  - When loss_run+1==LOSS_THRESH: go to SEARCH, locked<=0, run<=0, loss_run<=0 on that same edge.
- State encoding 3 is illegal and recovers to SEARCH on the next edge.
- clear:
  - Zeroes err_count on the next edge and has no effect on FSM or lock.
  - clear together with an enabled mismatch: err_count<=0 (clear wins), err_pulse still 1.
  - clear is honoured even when en=0.
- rst asserted mid-operation: all outputs return to reset values immediately, without waiting for clk.

Decomposition:
- Shared package pattern_chk_pkg:
  - state enum (SEARCH=0, LOCKING=1, LOCKED=2).
  - Default parameter constants.
- One sub-module: sat_counter (parameterised width; inc, clr, async rst; clr wins over inc; holds at all-ones). Used for err_count.
- The FSM, the prev/expected datapath and run/loss_run stay in the top module.

Test Plan:
Defaults are used unless a scenario says otherwise.
- Lock: after reset, en=1, din=0x10,0x11,0x12,0x13,0x14 -> locked=1 right after the 0x14 edge; state=2; err_count=0; no err_pulse.
- Wrap: once locked, din=0xFD,0xFE,0xFF,0x00,0x01 -> locked stays 1; err_count=0.
- Glitch: locked at 0x2F, din=0x30,0x31,0x99,0x33 -> one err_pulse, on the 0x99 edge; err_count=1; locked stays 1.
- Slip and relock:
  - Locked at 0x40, then din=0x80,0x81,0x82,0x83 -> 4 err_pulses, err_count=4, locked=0 and state=0 after the 0x83 edge.
  - Then 0x84..0x88 -> relocked after 0x88 (first sample enters LOCKING, plus 4 matches); err_count stays 4.
- Enable gaps: locked stream with en low for 3 cycles while din holds a bogus 0x00 -> no err_pulse; sequence resumes matching prev+1 -> still locked.
- Saturation, clear and reset:
  - ERR_CNT_WIDTH=4 with LOSS_THRESH=32: locked, then 20 isolated mismatches (each followed by a matching sample) -> err_count=15.
  - clear asserted on the same cycle as a mismatch -> err_count=0, err_pulse=1.
  - rst asserted mid-LOCKED between clock edges -> locked=0 and err_count=0 immediately.
